// File: rtl/mem_rsp_pkg.sv
// Shared types and helpers for the fixed-latency imem/dmem memory responder.
package mem_rsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1ECE_B000;

  // Width of a down-counter that must hold LAT-2.
  function automatic int lat_cnt_w(input int lat);
    return (lat <= 3) ? 1 : $clog2(lat - 1);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [31:0] word, input logic [3:0] mask);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = mask[b] ? word[8*b +: 8] : 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/mem_rsp_port.sv
// One request port: accepts a request, waits out its fixed latency, claims the
// array, latches the masked read word and pulses resp for one cycle.
module mem_rsp_port
  import mem_rsp_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  rmask_i,
  input  logic [3:0]  wmask_i,
  input  logic [31:0] wdata_i,
  input  logic        gnt_i,
  input  logic [31:0] arr_rdata_i,
  output logic        arr_req_o,
  output logic [31:0] addr_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic        resp_o,
  output logic [31:0] rdata_o
);

  localparam int            CW       = lat_cnt_w(LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 2);

  if (LAT < 2) begin : g_lat_chk
    $error("mem_rsp_port: LAT must be at least 2");
  end

  port_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resp_q, resp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    rmask_q, rmask_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_PEND: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (gnt_i) begin
          state_d = ST_RESP;
          resp_d  = 1'b1;
          rdata_d = lane_mask(arr_rdata_i, rmask_q);
        end
      end
      // IDLE and RESP both accept; requests arriving during PEND are dropped.
      default: begin
        state_d = ST_IDLE;
        if (req_i) begin
          state_d = ST_PEND;
          cnt_d   = CNT_INIT;
          addr_d  = addr_i;
          rmask_d = rmask_i;
          wmask_d = wmask_i;
          wdata_d = wdata_i;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    addr_q  <= addr_d;
    rmask_q <= rmask_d;
    wmask_q <= wmask_d;
    wdata_q <= wdata_d;
  end

  assign arr_req_o = (state_q == ST_PEND) && (cnt_q == '0);
  assign addr_o    = addr_q;
  assign wmask_o   = wmask_q;
  assign wdata_o   = wdata_q;
  assign resp_o    = resp_q;
  assign rdata_o   = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency imem/dmem responder over one single-ported word array; dmem
// always wins the array, imem retries on the following cycle.
module mem_responder
  import mem_rsp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          IMEM_LAT    = 2,
  parameter int          DMEM_LAT    = 3,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] imem_addr_i,
  input  logic [3:0]  imem_rmask_i,
  output logic [31:0] imem_rdata_o,
  output logic        imem_resp_o,
  input  logic [31:0] dmem_addr_i,
  input  logic [3:0]  dmem_rmask_i,
  input  logic [3:0]  dmem_wmask_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_resp_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if ((DEPTH_WORDS < 1) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_depth_chk
    $error("mem_responder: DEPTH_WORDS must be a power of two");
  end

  logic [31:0] mem [DEPTH_WORDS];

  logic             i_arr_req, d_arr_req, i_gnt, d_gnt;
  logic [31:0]      i_addr, d_addr, i_off, d_off, d_wdata, i_wdata, arr_rdata;
  logic [3:0]       i_wmask, d_wmask;
  logic [IDX_W-1:0] i_idx, d_idx, arr_idx;
  logic             unused_bits;

  mem_rsp_port #(.LAT(IMEM_LAT)) u_imem (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (|imem_rmask_i),
    .addr_i      (imem_addr_i),
    .rmask_i     (imem_rmask_i),
    .wmask_i     (4'h0),
    .wdata_i     (32'h0),
    .gnt_i       (i_gnt),
    .arr_rdata_i (arr_rdata),
    .arr_req_o   (i_arr_req),
    .addr_o      (i_addr),
    .wmask_o     (i_wmask),
    .wdata_o     (i_wdata),
    .resp_o      (imem_resp_o),
    .rdata_o     (imem_rdata_o)
  );

  mem_rsp_port #(.LAT(DMEM_LAT)) u_dmem (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (|(dmem_rmask_i | dmem_wmask_i)),
    .addr_i      (dmem_addr_i),
    .rmask_i     (dmem_rmask_i),
    .wmask_i     (dmem_wmask_i),
    .wdata_i     (dmem_wdata_i),
    .gnt_i       (d_gnt),
    .arr_rdata_i (arr_rdata),
    .arr_req_o   (d_arr_req),
    .addr_o      (d_addr),
    .wmask_o     (d_wmask),
    .wdata_o     (d_wdata),
    .resp_o      (dmem_resp_o),
    .rdata_o     (dmem_rdata_o)
  );

  // Gating with rst_ni keeps a write whose grant coincides with reset from landing.
  assign d_gnt = d_arr_req & rst_ni;
  assign i_gnt = i_arr_req & ~d_arr_req & rst_ni;

  assign i_off     = i_addr - BASE_ADDR;
  assign d_off     = d_addr - BASE_ADDR;
  assign i_idx     = i_off[IDX_W+1:2];
  assign d_idx     = d_off[IDX_W+1:2];
  assign arr_idx   = d_arr_req ? d_idx : i_idx;
  assign arr_rdata = mem[arr_idx];

  always_ff @(posedge clk_i) begin
    if (d_gnt) begin
      for (int b = 0; b < 4; b++) begin
        if (d_wmask[b]) mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
      end
    end
  end

  assign unused_bits = ^{i_wmask, i_wdata, i_off[1:0], d_off[1:0],
                         i_off[31:IDX_W+2], d_off[31:IDX_W+2]};

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a per-port expected-response scoreboard.
module tb_mem_responder;

  localparam logic [31:0] BASE     = 32'h1ECE_B000;
  localparam int          DEPTH    = 4096;
  localparam int          IMEM_LAT = 2;
  localparam int          DMEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] imem_addr_i;
  logic [3:0]  imem_rmask_i;
  logic [31:0] imem_rdata_o;
  logic        imem_resp_o;
  logic [31:0] dmem_addr_i;
  logic [3:0]  dmem_rmask_i;
  logic [3:0]  dmem_wmask_i;
  logic [31:0] dmem_wdata_i;
  logic [31:0] dmem_rdata_o;
  logic        dmem_resp_o;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .IMEM_LAT    (IMEM_LAT),
    .DMEM_LAT    (DMEM_LAT),
    .INIT_FILE   ("")
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .imem_addr_i  (imem_addr_i),
    .imem_rmask_i (imem_rmask_i),
    .imem_rdata_o (imem_rdata_o),
    .imem_resp_o  (imem_resp_o),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_rmask_i (dmem_rmask_i),
    .dmem_wmask_i (dmem_wmask_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_rdata_o (dmem_rdata_o),
    .dmem_resp_o  (dmem_resp_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock; sample #1 after the edge and retire any due or observed responses.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (imem_resp_o) begin
      if (iq.size() == 0) chk("imem_unexpected_resp", 32'(imem_resp_o), 32'd0);
      else begin
        e = iq.pop_front();
        chk("imem_rdata", imem_rdata_o, e.data);
        chk("imem_resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (iq.size() != 0 && iq[0].cyc <= cyc) begin
      e = iq.pop_front();
      chk("imem_missing_resp", 32'(imem_resp_o), 32'd1);
    end
    if (dmem_resp_o) begin
      if (dq.size() == 0) chk("dmem_unexpected_resp", 32'(dmem_resp_o), 32'd0);
      else begin
        e = dq.pop_front();
        chk("dmem_rdata", dmem_rdata_o, e.data);
        chk("dmem_resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
      e = dq.pop_front();
      chk("dmem_missing_resp", 32'(dmem_resp_o), 32'd1);
    end
  endtask

  task automatic dreq(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                      input logic [31:0] wd, input logic [31:0] expd);
    dmem_addr_i  = a;
    dmem_rmask_i = rm;
    dmem_wmask_i = wm;
    dmem_wdata_i = wd;
    dq.push_back('{expd, cyc + DMEM_LAT});
    tick();
    dmem_rmask_i = 4'h0;
    dmem_wmask_i = 4'h0;
  endtask

  task automatic ireq(input logic [31:0] a, input logic [3:0] rm, input logic [31:0] expd,
                      input int extra);
    imem_addr_i  = a;
    imem_rmask_i = rm;
    iq.push_back('{expd, cyc + IMEM_LAT + extra});
    tick();
    imem_rmask_i = 4'h0;
  endtask

  task automatic settle();
    for (int k = 0; k < 16; k++) begin
      if (iq.size() == 0 && dq.size() == 0) break;
      tick();
    end
    tick();
  endtask

  initial begin
    rst_ni       = 1'b0;
    imem_addr_i  = BASE;
    imem_rmask_i = 4'h0;
    dmem_addr_i  = BASE;
    dmem_rmask_i = 4'h0;
    dmem_wmask_i = 4'h0;
    dmem_wdata_i = 32'h0;
    tick();
    tick();
    chk("reset_imem_resp", 32'(imem_resp_o), 32'd0);
    chk("reset_dmem_resp", 32'(dmem_resp_o), 32'd0);
    chk("reset_imem_rdata", imem_rdata_o, 32'h0);
    chk("reset_dmem_rdata", dmem_rdata_o, 32'h0);
    rst_ni = 1'b1;
    tick();

    // Single fetch from word 0.
    dreq(BASE, 4'h0, 4'hF, 32'hDEAD_BEEF, 32'h0);
    settle();
    ireq(BASE, 4'hF, 32'hDEAD_BEEF, 0);
    settle();

    // Byte store into lane 1, then full-word load.
    dreq(BASE + 32'd4, 4'h0, 4'hF, 32'h1122_3344, 32'h0);
    settle();
    dreq(BASE + 32'd4, 4'h0, 4'b0010, 32'h0000_AB00, 32'h0);
    settle();
    dreq(BASE + 32'd4, 4'hF, 4'h0, 32'h0, 32'h1122_AB44);
    settle();

    // Collision: imem accepted one cycle after dmem loses one grant cycle.
    dreq(BASE, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF);
    ireq(BASE + 32'd4, 4'hF, 32'h1122_AB44, 1);
    settle();

    // Back-to-back fetch with the request held and the address stepping on each resp.
    for (int i = 0; i < 4; i++) begin
      dreq(BASE + 32'(8 + 4*i), 4'h0, 4'hF, 32'hA000_0000 + 32'(i), 32'h0);
      settle();
    end
    for (int i = 0; i < 4; i++) begin
      imem_addr_i  = BASE + 32'(8 + 4*i);
      imem_rmask_i = 4'hF;
      iq.push_back('{32'hA000_0000 + 32'(i), cyc + IMEM_LAT});
      tick();
      tick();
    end
    imem_rmask_i = 4'h0;
    settle();

    // Combined read+write returns the old word.
    dreq(BASE + 32'd4, 4'hF, 4'hF, 32'h5566_7788, 32'h1122_AB44);
    settle();
    dreq(BASE + 32'd4, 4'hF, 4'h0, 32'h0, 32'h5566_7788);
    settle();

    // dmem write granted one cycle before an imem read of the same word.
    dreq(BASE + 32'd24, 4'h0, 4'hF, 32'h0BAD_F00D, 32'h0);
    tick();
    ireq(BASE + 32'd24, 4'hF, 32'h0BAD_F00D, 0);
    settle();

    // Partial-lane reads through aliased addresses.
    dreq(BASE, 4'h0, 4'hF, 32'hCAFE_F00D, 32'h0);
    settle();
    ireq(BASE + 32'(4*DEPTH), 4'b0011, 32'h0000_F00D, 0);
    settle();
    dreq(BASE - 32'(4*DEPTH), 4'b1100, 4'h0, 32'h0, 32'hCAFE_0000);
    settle();

    // Reset one cycle after a write is accepted drops it and the response.
    dreq(BASE + 32'd28, 4'h0, 4'hF, 32'h7777_7777, 32'h0);
    settle();
    dreq(BASE + 32'd28, 4'hF, 4'h0, 32'h0, 32'h7777_7777);
    settle();
    dreq(BASE + 32'd28, 4'h0, 4'hF, 32'hBADB_ADBA, 32'h0);
    void'(dq.pop_back());
    rst_ni = 1'b0;
    tick();
    chk("midrst_imem_resp", 32'(imem_resp_o), 32'd0);
    chk("midrst_dmem_resp", 32'(dmem_resp_o), 32'd0);
    chk("midrst_imem_rdata", imem_rdata_o, 32'h0);
    chk("midrst_dmem_rdata", dmem_rdata_o, 32'h0);
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    dreq(BASE + 32'd28, 4'hF, 4'h0, 32'h0, 32'h7777_7777);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
